spi_write_ctrl: RTL

//  Sequences one SPI mode-0 write (CPOL=0, CPHA=0, MSB first) per start request.

---
 rtl/spi_write_pkg.sv | 34 +++
 rtl/spi_phase_timer.sv | 24 ++
 rtl/spi_write_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/spi_write_pkg.sv
// Shared SPI write/read sequencing types: phase states and phase-length lookup.
package spi_write_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Length in clk cycles of the phase spent in state s.
  function automatic int phase_len(input state_t s, input int setup, input int half,
                                   input int hold, input int idle);
    case (s)
      ST_SETUP:        return setup;
      ST_HIGH, ST_LOW: return half;
      ST_HOLD:         return hold;
      ST_GAP:          return idle;
      default:         return 1;
    endcase
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Reloadable phase down-counter: load latches len-1, expired flags the last phase cycle.
module spi_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             count <= '0;
    else if (load)          count <= len - W'(1);
    else if (count != '0)   count <= count - W'(1);
  end

  // Zero count alone marks expiry; the FSM derives load from it, so gating on
  // load here would close a combinational loop.
  assign expired = (count == '0);

endmodule

// File: rtl/spi_write_ctrl.sv
// SPI mode-0 write sequencer: one MSB-first frame per accepted start, all phases timed
// by a single reloadable phase timer.
module spi_write_ctrl
  import spi_write_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int HALF_PER = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi
);

  localparam int TW = $clog2(max4(HALF_PER, CS_SETUP, CS_HOLD, CS_IDLE) + 1);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state, nxt;
  logic [DATA_W-1:0] shreg, sh_nxt;
  logic [CW-1:0]     bitcnt;
  logic [TW-1:0]     len;
  logic              load, expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:  if (start)   nxt = ST_SETUP;
      ST_SETUP: if (expired) nxt = ST_HIGH;
      ST_HIGH:  if (expired) nxt = (bitcnt == '0) ? ST_HOLD : ST_LOW;
      ST_LOW:   if (expired) nxt = ST_HIGH;
      ST_HOLD:  if (expired) nxt = ST_GAP;
      ST_GAP:   if (expired) nxt = ST_IDLE;
      default:               nxt = ST_IDLE;
    endcase
  end

  // Reload on every entry into a timed phase, with the length of the phase being entered.
  assign load   = (nxt != state) && (nxt != ST_IDLE);
  assign len    = TW'(phase_len(nxt, CS_SETUP, HALF_PER, CS_HOLD, CS_IDLE));
  assign sh_nxt = shreg << 1;

  spi_phase_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .len     (len),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      bitcnt <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cs_n   <= 1'b1;
      sclk   <= 1'b0;
      mosi   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: if (start) begin
          shreg  <= din;
          mosi   <= din[DATA_W-1];
          cs_n   <= 1'b0;
          busy   <= 1'b1;
          bitcnt <= CW'(DATA_W - 1);
        end
        ST_SETUP: if (expired) sclk <= 1'b1;
        // Next bit is presented on the falling edge so it is stable across the rise.
        ST_HIGH: if (expired) begin
          sclk <= 1'b0;
          if (bitcnt != '0) begin
            shreg  <= sh_nxt;
            mosi   <= sh_nxt[DATA_W-1];
            bitcnt <= bitcnt - CW'(1);
          end
        end
        ST_LOW:  if (expired) sclk <= 1'b1;
        ST_HOLD: if (expired) cs_n <= 1'b1;
        ST_GAP: if (expired) begin
          done <= 1'b1;
          busy <= 1'b0;
          mosi <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
